// File: rtl/fast_row_feeder.sv
// 7-row column feeder: six line buffers build a vertical 7-pixel column per accepted pixel.
// Optional macro FEEDER_ZERO_FILL_EN zeroes rows not yet filled in the current frame.
module fast_row_feeder #(
   parameter int IMG_W = 640,
   parameter int CW    = 11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pix_in,
   input  logic       pix_valid,
   input  logic       sof,
   output logic [7:0] data1,
   output logic [7:0] data2,
   output logic [7:0] data3,
   output logic [7:0] data4,
   output logic [7:0] data5,
   output logic [7:0] data6,
   output logic [7:0] data7,
   output logic       load,
   output logic       win_valid,
   output logic       line_end
);

   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

   // One wide word per column: byte k is line buffer k (row r-1-k).
   logic [47:0]   lb_mem [0:IMG_W-1];
   logic [47:0]   rd_word;
   logic          accept;
   logic [CW-1:0] col_reg, col_next, eff_col;
   logic [2:0]    row_fill_reg, row_fill_next, eff_row;
   logic [7:0]    cur_reg;
   logic          load_reg, win_reg, line_end_reg;

   assign accept  = pix_valid & ~reset;
   assign eff_col = sof ? '0 : col_reg;
   assign eff_row = sof ? 3'd0 : row_fill_reg;
   assign rd_word = lb_mem[eff_col[AW-1:0]];

   always_comb begin
      col_next      = col_reg;
      row_fill_next = row_fill_reg;
      if (eff_col == LAST_COL) begin
         col_next      = '0;
         row_fill_next = (eff_row == 3'd6) ? 3'd6 : eff_row + 3'd1;
      end else begin
         col_next      = eff_col + CW'(1);
         row_fill_next = eff_row;
      end
   end

   // Buffer contents survive reset and sof; a reset cycle discards its pixel.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_mem[eff_col[AW-1:0]] <= {rd_word[39:0], pix_in};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_reg      <= '0;
         row_fill_reg <= 3'd0;
         cur_reg      <= 8'h00;
         load_reg     <= 1'b0;
         win_reg      <= 1'b0;
         line_end_reg <= 1'b0;
      end else if (pix_valid) begin
         col_reg      <= col_next;
         row_fill_reg <= row_fill_next;
         cur_reg      <= pix_in;
         load_reg     <= 1'b1;
         win_reg      <= (eff_row == 3'd6) && (eff_col >= CW'(6));
         line_end_reg <= (eff_col == LAST_COL);
      end else begin
         load_reg     <= 1'b0;
         win_reg      <= 1'b0;
         line_end_reg <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_tap
         logic [7:0] tap_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               tap_reg <= 8'h00;
            end else if (pix_valid) begin
`ifdef FEEDER_ZERO_FILL_EN
               tap_reg <= (eff_row > 3'(gi)) ? rd_word[8*gi +: 8] : 8'h00;
`else
               tap_reg <= rd_word[8*gi +: 8];
`endif
            end
         end
      end
   endgenerate

   assign data1     = g_tap[5].tap_reg;
   assign data2     = g_tap[4].tap_reg;
   assign data3     = g_tap[3].tap_reg;
   assign data4     = g_tap[2].tap_reg;
   assign data5     = g_tap[1].tap_reg;
   assign data6     = g_tap[0].tap_reg;
   assign data7     = cur_reg;
   assign load      = load_reg;
   assign win_valid = win_reg;
   assign line_end  = line_end_reg;

endmodule

// File: tb/tb_fast_row_feeder.sv
// Scoreboard bench for fast_row_feeder at IMG_W=8: driver pushes expected per cycle,
// negedge monitor pops and compares, directed captures are checked against hand values.
module tb_fast_row_feeder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pix_in = 8'h00;
   logic       pix_valid = 1'b0;
   logic       sof = 1'b0;
   logic [7:0] data1, data2, data3, data4, data5, data6, data7;
   logic       load, win_valid, line_end;

   always #5 clk = ~clk;

   fast_row_feeder #(.IMG_W(8), .CW(3)) dut (
      .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
      .data1(data1), .data2(data2), .data3(data3), .data4(data4),
      .data5(data5), .data6(data6), .data7(data7),
      .load(load), .win_valid(win_valid), .line_end(line_end)
   );

   typedef struct packed {
      logic        load;
      logic        win;
      logic        le;
      logic [55:0] d;
      logic [6:0]  mask;
      logic [7:0]  tag;
   } exp_t;

   exp_t exp_q [$];
   int checks = 0;
   int failures = 0;
   int loads_seen = 0;
   int wins_seen = 0;
   int accepted = 0;
   logic started = 1'b0;
   logic [55:0] cap [0:7];

   // Reference model state
   logic [7:0]  m_lb [0:5][0:7];
   logic        m_lbv [0:5][0:7];
   int          m_col = 0;
   int          m_row = 0;
   logic [55:0] m_d = '0;
   logic [6:0]  m_mask = '0;

   logic [55:0] dut_d;
   assign dut_d = {data7, data6, data5, data4, data3, data2, data1};

   exp_t mon_e;
   logic mon_ok;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         mon_ok = (load === mon_e.load) && (win_valid === mon_e.win) && (line_end === mon_e.le);
         for (int j = 0; j < 7; j++) begin
            if (mon_e.mask[j] && (dut_d[8*j +: 8] !== mon_e.d[8*j +: 8])) mon_ok = 1'b0;
         end
         if (!mon_ok) begin
            failures++;
            $display("FAIL out_check t=%0t got load=%b win=%b le=%b data=%h exp load=%b win=%b le=%b data=%h mask=%b",
                     $time, load, win_valid, line_end, dut_d, mon_e.load, mon_e.win, mon_e.le, mon_e.d, mon_e.mask);
         end
         if (load === 1'b1) begin
            loads_seen++;
            $display("txn t=%0t data=%h win=%b le=%b", $time, dut_d, win_valid, line_end);
         end
         if (win_valid === 1'b1) wins_seen++;
         if (mon_e.tag != 8'd0) cap[mon_e.tag[2:0]] = dut_d;
      end else if (started && load !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_load t=%0t got load=%b exp 0", $time, load);
      end
   end

   task automatic step(input logic v, input logic s, input logic r, input logic [7:0] p, input logic [7:0] tg);
      exp_t e;
      int ec, er;
      logic [7:0] old [0:5];
      logic oldv [0:5];
      logic zf;
      @(negedge clk);
      #1;
      pix_valid = v; sof = s; reset = r; pix_in = p;
      e = '0;
      if (r) begin
         m_col = 0; m_row = 0; m_d = '0; m_mask = '1;
      end else if (v) begin
         ec = s ? 0 : m_col;
         er = s ? 0 : m_row;
         for (int k = 0; k < 6; k++) begin
            old[k] = m_lb[k][ec];
            oldv[k] = m_lbv[k][ec];
         end
         m_d[48 +: 8] = p;
         m_mask[6] = 1'b1;
         for (int k = 0; k < 6; k++) begin
            zf = 1'b0;
`ifdef FEEDER_ZERO_FILL_EN
            zf = (k >= er);
`endif
            if (zf) begin
               m_d[8*(5-k) +: 8] = 8'h00;
               m_mask[5-k] = 1'b1;
            end else begin
               m_d[8*(5-k) +: 8] = old[k];
               m_mask[5-k] = oldv[k];
            end
         end
         for (int k = 5; k > 0; k--) begin
            m_lb[k][ec] = old[k-1];
            m_lbv[k][ec] = oldv[k-1];
         end
         m_lb[0][ec] = p;
         m_lbv[0][ec] = 1'b1;
         e.load = 1'b1;
         e.win = (er == 6) && (ec >= 6);
         e.le = (ec == 7);
         if (ec == 7) begin
            m_col = 0;
            m_row = (er == 6) ? 6 : er + 1;
         end else begin
            m_col = ec + 1;
            m_row = er;
         end
         accepted++;
      end
      e.d = m_d;
      e.mask = m_mask;
      e.tag = tg;
      exp_q.push_back(e);
      started = 1'b1;
   endtask

   task automatic drain();
      @(negedge clk);
      #1;
      pix_valid = 1'b0; sof = 1'b0; reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout got pending=%0d exp 0", exp_q.size());
      end
   endtask

   task automatic check_val(input string name, input logic [55:0] got, input logic [55:0] want, input logic [55:0] msk);
      checks++;
      if ((got & msk) !== (want & msk)) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got & msk, want & msk);
      end
   endtask

   localparam logic [55:0] WIN_COL = 56'h66_56_46_36_26_16_06;
   localparam logic [55:0] ALL = '1;

   initial begin
      int n;
      for (int k = 0; k < 6; k++) for (int c = 0; c < 8; c++) m_lbv[k][c] = 1'b0;
      for (int t = 0; t < 8; t++) cap[t] = '0;

      // Reset state
      step(1'b0, 1'b0, 1'b1, 8'h00, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'h00, 8'd0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'd0);

      // Continuous frame
      wins_seen = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            step(1'b1, (r == 0 && c == 0), 1'b0, 8'(16*r + c), (r == 6 && c == 6) ? 8'd1 : 8'd0);
      drain();
      check_val("first_window_cont", cap[1], WIN_COL, ALL);
      check_val("win_count_cont", 56'(wins_seen), 56'd4, ALL);

      // Same frame with every third cycle idle
      wins_seen = 0; loads_seen = 0; accepted = 0; n = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            if (n % 3 == 2) begin
               step(1'b0, 1'b0, 1'b0, 8'hEE, 8'd0);
               n++;
            end
            step(1'b1, (r == 0 && c == 0), 1'b0, 8'(16*r + c), (r == 6 && c == 6) ? 8'd2 : 8'd0);
            n++;
         end
      drain();
      check_val("first_window_gaps", cap[2], WIN_COL, ALL);
      check_val("load_vs_accepted", 56'(loads_seen), 56'(accepted), ALL);
      check_val("win_count_gaps", 56'(wins_seen), 56'd4, ALL);

      // Mid-row sof restart at row 3 col 4
      for (int i = 0; i < 28; i++) step(1'b1, (i == 0), 1'b0, 8'(16*(i/8) + i%8), 8'd0);
      wins_seen = 0;
      for (int i = 0; i < 48; i++) step(1'b1, (i == 0), 1'b0, 8'(8'h80 + 16*(i/8) + i%8), 8'd0);
      drain();
      check_val("no_win_after_restart", 56'(wins_seen), 56'd0, ALL);
      for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 1'b0, 8'(8'hE0 + c), 8'd0);
      drain();
      check_val("win_row6_after_restart", 56'(wins_seen), 56'd2, ALL);

      // Reset coincident with a valid pixel mid-frame
      for (int i = 0; i < 19; i++) step(1'b1, (i == 0), 1'b0, 8'(8'h30 + i), 8'd0);
      step(1'b1, 1'b0, 1'b1, 8'h77, 8'd3);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h90 + i), 8'd0);
      drain();
      check_val("reset_clears_data", cap[3], 56'h0, ALL);

      // Row 2 of a fresh frame: unfilled rows
      for (int i = 0; i < 17; i++)
         step(1'b1, (i == 0), 1'b0, 8'(8'hC0 + i), (i == 16) ? 8'd5 : 8'd0);
      drain();
      check_val("row2_filled_rows", cap[5], 56'hD0_C8_C0_00_00_00_00, 56'hFF_FF_FF_00_00_00_00);
`ifdef FEEDER_ZERO_FILL_EN
      check_val("row2_zero_fill", cap[5], 56'h0, 56'h00_00_00_FF_FF_FF_FF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
